// File: rtl/pipeline_control_unit.sv
// Central control for the 5-stage pipeline: EX forwarding selects, load-use stall,
// and the run/step/halt-drain sequencer that gates every stage-register enable.
module pipeline_control_unit #(
    parameter int NB_REG       = 5,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mode_run,
    input  logic              i_step,
    input  logic              i_halt_detected,
    input  logic [NB_REG-1:0] i_ifid_rs,
    input  logic [NB_REG-1:0] i_ifid_rt,
    input  logic [NB_REG-1:0] i_idex_rs,
    input  logic [NB_REG-1:0] i_idex_rt,
    input  logic              i_idex_mem_read,
    input  logic [NB_REG-1:0] i_exmem_write_reg,
    input  logic              i_exmem_wb_write,
    input  logic [NB_REG-1:0] i_memwb_write_reg,
    input  logic              i_memwb_wb_write,
    output logic [1:0]        o_corto_rs,
    output logic [1:0]        o_corto_rt,
    output logic              o_stall,
    output logic              o_pipeline_enable,
    output logic              o_done,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int NB_CNT = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_CNT-1:0] DRAIN_LOAD = NB_CNT'(DRAIN_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_ONE    = NB_CNT'(1);

    state_t            state, state_next;
    logic [NB_CNT-1:0] drain_cnt, drain_cnt_next;
    logic              raw;
    logic              halt_accept;

    // Forwarding: MEM result beats WB result; register 0 is hardwired and never forwarded.
    always_comb begin
        o_corto_rs = 2'b00;
        o_corto_rt = 2'b00;
        if (i_exmem_wb_write && (i_exmem_write_reg == i_idex_rs) && (i_idex_rs != '0))
            o_corto_rs = 2'b10;
        else if (i_memwb_wb_write && (i_memwb_write_reg == i_idex_rs) && (i_idex_rs != '0))
            o_corto_rs = 2'b01;
        if (i_exmem_wb_write && (i_exmem_write_reg == i_idex_rt) && (i_idex_rt != '0))
            o_corto_rt = 2'b10;
        else if (i_memwb_wb_write && (i_memwb_write_reg == i_idex_rt) && (i_idex_rt != '0))
            o_corto_rt = 2'b01;
    end

    assign raw = i_idex_mem_read && (i_idex_rt != '0) &&
                 ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

    // A HALT sitting behind a load-use bubble is not taken; it is re-seen next cycle.
    assign halt_accept = i_halt_detected && o_pipeline_enable && !o_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        unique case (state)
            IDLE: begin
                if (i_mode_run)  state_next = RUN;
                else if (i_step) state_next = STEP;
            end
            RUN: begin
                if (halt_accept) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            STEP: begin
                if (halt_accept) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (!o_stall) begin
                    drain_cnt_next = drain_cnt - CNT_ONE;
                    if (drain_cnt == CNT_ONE) state_next = DONE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_pipeline_enable = (state == RUN) || (state == STEP) || (state == DRAIN);
        o_done            = (state == DONE);
        o_stall           = raw && o_pipeline_enable;
        o_state           = state;
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: forwarding, load-use stall, step/run/halt-drain.
module tb_pipeline_control_unit;

    logic       i_clk = 1'b0;
    logic       i_reset, i_mode_run, i_step, i_halt_detected;
    logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rs, i_idex_rt;
    logic       i_idex_mem_read;
    logic [4:0] i_exmem_write_reg, i_memwb_write_reg;
    logic       i_exmem_wb_write, i_memwb_wb_write;
    logic [1:0] o_corto_rs, o_corto_rt;
    logic       o_stall, o_pipeline_enable, o_done;
    logic [2:0] o_state;

    int unsigned passed = 0;
    int unsigned total  = 0;

    pipeline_control_unit #(.NB_REG(5), .DRAIN_CYCLES(4)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_mode_run        (i_mode_run),
        .i_step            (i_step),
        .i_halt_detected   (i_halt_detected),
        .i_ifid_rs         (i_ifid_rs),
        .i_ifid_rt         (i_ifid_rt),
        .i_idex_rs         (i_idex_rs),
        .i_idex_rt         (i_idex_rt),
        .i_idex_mem_read   (i_idex_mem_read),
        .i_exmem_write_reg (i_exmem_write_reg),
        .i_exmem_wb_write  (i_exmem_wb_write),
        .i_memwb_write_reg (i_memwb_write_reg),
        .i_memwb_wb_write  (i_memwb_wb_write),
        .o_corto_rs        (o_corto_rs),
        .o_corto_rt        (o_corto_rt),
        .o_stall           (o_stall),
        .o_pipeline_enable (o_pipeline_enable),
        .o_done            (o_done),
        .o_state           (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_raw(input logic on);
        i_idex_mem_read = on;
        i_idex_rt       = on ? 5'd5 : 5'd0;
        i_ifid_rt       = on ? 5'd5 : 5'd0;
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_mode_run = 1'b0; i_step = 1'b0; i_halt_detected = 1'b0;
        i_ifid_rs = '0; i_ifid_rt = '0; i_idex_rs = '0; i_idex_rt = '0;
        i_idex_mem_read = 1'b0;
        i_exmem_write_reg = '0; i_exmem_wb_write = 1'b0;
        i_memwb_write_reg = '0; i_memwb_wb_write = 1'b0;
        tick(); tick();
        chk("rst_state", 8'(o_state), 8'd0);
        chk("rst_enable", 8'(o_pipeline_enable), 8'd0);
        chk("rst_done", 8'(o_done), 8'd0);
        chk("rst_stall", 8'(o_stall), 8'd0);
        i_reset = 1'b0;
        tick();
        chk("idle_hold", 8'(o_state), 8'd0);

        // Forwarding priority and r0 exclusion
        i_idex_rs = 5'd3; i_exmem_write_reg = 5'd3; i_exmem_wb_write = 1'b1;
        i_memwb_write_reg = 5'd3; i_memwb_wb_write = 1'b1; #1;
        chk("fwd_rs_mem", 8'(o_corto_rs), 8'd2);
        chk("fwd_rt_none", 8'(o_corto_rt), 8'd0);
        i_exmem_wb_write = 1'b0; #1;
        chk("fwd_rs_wb", 8'(o_corto_rs), 8'd1);
        i_idex_rs = 5'd0; i_exmem_write_reg = 5'd0; i_memwb_write_reg = 5'd0; #1;
        chk("fwd_rs_r0", 8'(o_corto_rs), 8'd0);
        i_idex_rt = 5'd7; i_exmem_write_reg = 5'd7; i_exmem_wb_write = 1'b1;
        i_memwb_write_reg = 5'd9; #1;
        chk("fwd_rt_mem", 8'(o_corto_rt), 8'd2);
        i_exmem_write_reg = 5'd9; i_memwb_write_reg = 5'd7; #1;
        chk("fwd_rt_wb", 8'(o_corto_rt), 8'd1);
        i_memwb_wb_write = 1'b0; #1;
        chk("fwd_rt_nowr", 8'(o_corto_rt), 8'd0);
        i_idex_rt = '0; i_exmem_write_reg = '0; i_memwb_write_reg = '0;
        i_exmem_wb_write = 1'b0;

        set_raw(1'b1);
        chk("stall_idle", 8'(o_stall), 8'd0);
        set_raw(1'b0);

        // Step mode: three single enabled cycles; second one holds i_step through STEP
        for (int i = 0; i < 3; i++) begin
            i_step = 1'b1;
            tick();
            if (i != 1) i_step = 1'b0;
            #1;
            chk("step_state", 8'(o_state), 8'd2);
            chk("step_en", 8'(o_pipeline_enable), 8'd1);
            tick();
            i_step = 1'b0;
            #1;
            chk("step_back", 8'(o_state), 8'd0);
            chk("step_en_off", 8'(o_pipeline_enable), 8'd0);
        end

        // Halt during STEP drains automatically; reset mid-DRAIN with counter at 2
        i_step = 1'b1;
        tick();
        i_step = 1'b0; i_halt_detected = 1'b1; #1;
        tick();
        i_halt_detected = 1'b0;
        chk("stephalt_drain", 8'(o_state), 8'd3);
        tick(); tick();
        chk("drain_cnt2", 8'(o_state), 8'd3);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rstdrain_state", 8'(o_state), 8'd0);
        chk("rstdrain_done", 8'(o_done), 8'd0);
        chk("rstdrain_en", 8'(o_pipeline_enable), 8'd0);

        // Run and step together: run wins; run persists after i_mode_run drops
        i_mode_run = 1'b1; i_step = 1'b1;
        tick();
        i_mode_run = 1'b0; i_step = 1'b0;
        chk("run_wins", 8'(o_state), 8'd1);
        set_raw(1'b1);
        chk("stall_run", 8'(o_stall), 8'd1);
        i_idex_rt = 5'd0; #1;
        chk("stall_r0", 8'(o_stall), 8'd0);
        i_idex_rt = 5'd5; i_ifid_rt = 5'd0; i_ifid_rs = 5'd5; #1;
        chk("stall_rs", 8'(o_stall), 8'd1);
        i_idex_mem_read = 1'b0; #1;
        chk("stall_noload", 8'(o_stall), 8'd0);
        i_ifid_rs = '0;
        set_raw(1'b0);
        tick();
        chk("run_persist", 8'(o_state), 8'd1);

        // Halt coinciding with a stall is deferred one cycle; stall in DRAIN extends it
        set_raw(1'b1);
        i_halt_detected = 1'b1; #1;
        tick();
        chk("halt_stalled", 8'(o_state), 8'd1);
        set_raw(1'b0);
        tick();
        chk("halt_late", 8'(o_state), 8'd3);
        tick();
        chk("drain_c3", 8'(o_state), 8'd3);
        set_raw(1'b1);
        chk("drain_stall", 8'(o_stall), 8'd1);
        tick();
        set_raw(1'b0);
        chk("drain_ext", 8'(o_state), 8'd3);
        tick();
        chk("drain_c2", 8'(o_state), 8'd3);
        tick();
        chk("drain_c1", 8'(o_state), 8'd3);
        chk("drain_en", 8'(o_pipeline_enable), 8'd1);
        tick();
        i_halt_detected = 1'b0;
        chk("stall_done_state", 8'(o_state), 8'd4);
        chk("stall_done_flag", 8'(o_done), 8'd1);

        // Clean run to halt at cycle 10: DRAIN 11-14, DONE from 15
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst2_state", 8'(o_state), 8'd0);
        i_mode_run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("run_cycle", 8'(o_state), 8'd1);
        end
        i_halt_detected = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("drain_state", 8'(o_state), 8'd3);
            chk("drain_enable", 8'(o_pipeline_enable), 8'd1);
            tick();
        end
        i_halt_detected = 1'b0;
        i_step = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("done_state", 8'(o_state), 8'd4);
            chk("done_flag", 8'(o_done), 8'd1);
            chk("done_en", 8'(o_pipeline_enable), 8'd0);
            tick();
        end
        i_step = 1'b0; i_mode_run = 1'b0;

        // Restart after reset
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0; i_mode_run = 1'b1;
        chk("restart_idle", 8'(o_state), 8'd0);
        tick();
        chk("restart_run", 8'(o_state), 8'd1);
        chk("restart_done", 8'(o_done), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Central controller for the 5-stage MIPS pipeline.
- Produces the EX-stage forwarding selects (corto_rs/corto_rt) and the load-use stall/bubble.
- Sequences pipeline execution through a run/step/halt-drain state machine driven by the debug unit.
- Sits beside the IF/ID/EX/MEM/WB stage registers; its outputs gate every stage-register enable.

Parameters:
NB_REG, 5, register-index width
DRAIN_CYCLES, 4, enabled (non-stalled) cycles granted after HALT is decoded so older instructions retire through WB

Ports:
i_clk  in  1  clock
i_reset  in  1  reset
i_mode_run  in  1  level; start continuous execution
i_step  in  1  one-cycle pulse; advance pipeline one cycle
i_halt_detected  in  1  HALT opcode present in ID stage
i_ifid_rs  in  NB_REG  rs of instruction in ID
i_ifid_rt  in  NB_REG  rt of instruction in ID
i_idex_rs  in  NB_REG  rs of instruction in EX
i_idex_rt  in  NB_REG  rt of instruction in EX
i_idex_mem_read  in  1  EX instruction is a load
i_exmem_write_reg  in  NB_REG  destination register of instruction in MEM
i_exmem_wb_write  in  1  MEM instruction writes the register file
i_memwb_write_reg  in  NB_REG  destination register of instruction in WB
i_memwb_wb_write  in  1  WB instruction writes the register file
o_corto_rs  out  2  EX operand A select: 00 register bank, 01 WB value, 10 MEM ALU result
o_corto_rt  out  2  EX operand B select, same encoding
o_stall  out  1  hold PC and IF/ID; insert bubble (zero control) into ID/EX
o_pipeline_enable  out  1  global stage-register enable
o_done  out  1  program finished, pipeline drained
o_state  out  3  FSM state for the debug unit

Behaviour:
- Clock and reset: i_reset is synchronous and active-high; clock is i_clk.
- Reset values: state IDLE (3'd0), drain counter 0, o_pipeline_enable 0, o_done 0, o_stall 0.
- Forwarding is combinational and independent of FSM state. Per operand (rs shown; rt identical):
  - 10 if i_exmem_wb_write and i_exmem_write_reg == i_idex_rs and i_idex_rs != 0.
  - Else 01 if i_memwb_wb_write and i_memwb_write_reg == i_idex_rs and i_idex_rs != 0.
  - Else 00.
  - MEM has priority over WB. Register 0 is never forwarded. Encoding 11 is never produced.
- Load-use stall:
  - raw = i_idex_mem_read and i_idex_rt != 0 and (i_idex_rt == i_ifid_rs or i_idex_rt == i_ifid_rt).
  - o_stall = raw and o_pipeline_enable.
  - The bubble advances the load to MEM, so raw self-clears after exactly one enabled cycle.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. o_pipeline_enable=1 in RUN, STEP and DRAIN only.
- Halt is accepted only when i_halt_detected and o_pipeline_enable and !o_stall. A stalled HALT is re-seen next cycle.
- IDLE:
  - i_mode_run → RUN. Otherwise i_step → STEP.
  - Both asserted together: RUN wins.
- RUN: accepted halt → DRAIN, counter <= DRAIN_CYCLES. i_mode_run deasserting does not stop RUN.
- STEP: enabled exactly one cycle.
  - Accepted halt → DRAIN; the drain then completes automatically.
  - Otherwise → IDLE.
  - While in STEP, further i_step pulses are ignored.
- DRAIN:
  - Counter decrements only on cycles with o_stall=0.
  - Transition to DONE on the cycle the counter decrements from 1 to 0, giving exactly DRAIN_CYCLES non-stalled enabled cycles.
  - i_halt_detected is ignored in DRAIN.
- DONE: o_done=1, enable 0. Absorbing; only i_reset leaves it. i_step and i_mode_run are ignored.
- Reset mid-operation (including during DRAIN) returns to IDLE with the counter cleared on the next edge.
- o_state is a registered copy of the state encoding.

Test Plan:
- Forwarding priority: idex_rs=3, exmem_write_reg=3 (wb_write=1), memwb_write_reg=3 (wb_write=1) → o_corto_rs=10. Clear exmem_wb_write → 01. Set idex_rs=0 → 00.
- Load-use: RUN, idex_mem_read=1, idex_rt=5, ifid_rt=5 → o_stall=1 for one cycle. Same with idex_rt=0 → o_stall=0. Same in IDLE → o_stall=0.
- Step mode: three i_step pulses from IDLE → o_pipeline_enable high for exactly 3 single cycles; o_state toggles 0→2→0 each time.
- Run to halt (DRAIN_CYCLES=4): i_mode_run=1, i_halt_detected=1 at cycle 10 → DRAIN cycles 11–14, o_done=1 and enable=0 from cycle 15, held for ≥20 cycles.
- Halt during stall: halt and raw stall coincide → halt not accepted that cycle; DRAIN entered one cycle later. A stall inside DRAIN extends the enabled window by one cycle.
- Reset mid-DRAIN: assert i_reset with counter=2 → next edge state IDLE, o_done=0, enable 0. A subsequent i_mode_run restarts normally.
